// File: rtl/snoop_bus_arbiter_pkg.sv
// Shared definitions for the MESI snooping bus: command encodings seen by
// processors, arbiter and memory, plus the arbiter's FSM state encoding.
package snoop_bus_arbiter_pkg;

    localparam int MAX_PROC = 4;

    typedef enum logic [1:0] {
        CMD_RD_MISS = 2'b00,
        CMD_WR_MISS = 2'b01,
        CMD_INV     = 2'b10,
        CMD_RSV     = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_SNOOP = 3'd2,
        ST_WB    = 3'd3,
        ST_MEM   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // True when more than one bit of v is set.
    function automatic logic multi_hot(input logic [MAX_PROC-1:0] v);
        return (v & (v - MAX_PROC'(1))) != '0;
    endfunction

    // The reserved encoding behaves exactly like an invalidate.
    function automatic logic is_inv(input cmd_t c);
        return (c == CMD_INV) || (c == CMD_RSV);
    endfunction

endpackage

// File: rtl/snoop_bus_arbiter_if.sv
// Bundle of request, broadcast, snoop-response, memory and completion
// signals between the bus arbiter (master) and caches/memory (slave).
interface snoop_bus_arbiter_if #(
    parameter int N_PROC = 3,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    import snoop_bus_arbiter_pkg::*;

    logic [N_PROC-1:0]        req;
    logic [2*N_PROC-1:0]      req_cmd;
    logic [ADDR_W*N_PROC-1:0] req_addr;
    logic [DATA_W*N_PROC-1:0] req_wdata;
    logic [N_PROC-1:0]        gnt;
    logic                     bus_valid;
    cmd_t                     bus_cmd;
    logic [ADDR_W-1:0]        bus_addr;
    logic [N_PROC-1:0]        snoop_share;
    logic [N_PROC-1:0]        snoop_wb;
    logic [DATA_W*N_PROC-1:0] snoop_wb_data;
    logic                     mem_rd;
    logic                     mem_wr;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic [DATA_W-1:0]        mem_rdata;
    logic                     mem_ack;
    logic [N_PROC-1:0]        done;
    logic                     done_share;
    logic [DATA_W-1:0]        done_data;
    logic                     proto_err;

    modport master (
        input  req, req_cmd, req_addr, req_wdata,
        input  snoop_share, snoop_wb, snoop_wb_data,
        input  mem_rdata, mem_ack,
        output gnt, bus_valid, bus_cmd, bus_addr,
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        output done, done_share, done_data, proto_err
    );

    modport slave (
        output req, req_cmd, req_addr, req_wdata,
        output snoop_share, snoop_wb, snoop_wb_data,
        output mem_rdata, mem_ack,
        input  gnt, bus_valid, bus_cmd, bus_addr,
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        input  done, done_share, done_data, proto_err
    );

endinterface

// File: rtl/snoop_bus_arbiter_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, wrapping.
// Purely combinational; the parent registers the result.
module snoop_bus_arbiter_rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     win_oh,
    output logic [PTR_W-1:0] win_idx
);

    logic found;

    // Scan offsets from the pointer; the first requester hit wins.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int o = 0; o < N; o++) begin
            for (int c = 0; c < N; c++) begin
                if (!found && req[c] && (((int'(ptr) + o) % N) == c)) begin
                    found     = 1'b1;
                    win_oh[c] = 1'b1;
                    win_idx   = PTR_W'(c);
                end
            end
        end
    end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snooping-bus arbiter: grants one processor per transaction round-robin and
// sequences broadcast, snoop collection, write-back, memory access, completion.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | sample req, latch winner's cmd/addr/wdata
//   ST_ADDR  | one-cycle broadcast on bus_valid/bus_cmd/bus_addr
//   ST_SNOOP | wait SNOOP_CYC cycles, then sample share/wb responses
//   ST_WB    | write the snooper's M copy back to memory
//   ST_MEM   | read fill (read miss) or write owner data (write miss)
//   ST_DONE  | one-cycle done pulse, advance rr pointer
module snoop_bus_arbiter
    import snoop_bus_arbiter_pkg::*;
#(
    parameter int N_PROC    = 3,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 8,
    parameter int SNOOP_CYC = 1
) (
    input  logic           clock,
    input  logic           reset_n,
    snoop_bus_arbiter_if.master bus
);

    localparam int PTR_W = (N_PROC > 2) ? 2 : 1;
    localparam int CNT_W = 2;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rr_q, owner_idx_q, win_idx;
    logic [N_PROC-1:0]   win_oh, owner_q, share_m, wb_m;
    cmd_t                cmd_q, win_cmd;
    logic [ADDR_W-1:0]   addr_q, win_addr;
    logic [DATA_W-1:0]   wdata_q, win_wdata, wb_data_q, fill_q, wb_sel;
    logic [CNT_W-1:0]    snoop_cnt_q;
    logic                done_share_q, proto_err_q, snoop_tc;

    snoop_bus_arbiter_rr_arbiter #(.N(N_PROC), .PTR_W(PTR_W)) u_rr_arbiter (
        .req     (bus.req),
        .ptr     (rr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    // The owner never snoops its own transaction.
    assign share_m       = bus.snoop_share & ~owner_q;
    assign wb_m          = bus.snoop_wb & ~owner_q;
    assign snoop_tc      = (snoop_cnt_q == '0);
    assign bus.proto_err = proto_err_q;

    // Select the winner's request fields and the lowest-index write-back data.
    always_comb begin
        win_cmd   = CMD_RD_MISS;
        win_addr  = '0;
        win_wdata = '0;
        wb_sel    = '0;
        for (int i = 0; i < N_PROC; i++) begin
            if (win_oh[i]) begin
                win_cmd   = cmd_t'(bus.req_cmd[2*i +: 2]);
                win_addr  = bus.req_addr[ADDR_W*i +: ADDR_W];
                win_wdata = bus.req_wdata[DATA_W*i +: DATA_W];
            end
        end
        for (int i = N_PROC - 1; i >= 0; i--) begin
            if (wb_m[i]) wb_sel = bus.snoop_wb_data[DATA_W*i +: DATA_W];
        end
    end

    // State register; reset aborts any transaction at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state and bus/memory/completion outputs, all decoded from registers.
    always_comb begin
        state_d        = state_q;
        bus.gnt        = '0;
        bus.bus_valid  = 1'b0;
        bus.bus_cmd    = CMD_RD_MISS;
        bus.bus_addr   = '0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.done       = '0;
        bus.done_share = 1'b0;
        bus.done_data  = '0;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                bus.gnt       = owner_q;
                bus.bus_valid = 1'b1;
                bus.bus_cmd   = cmd_q;
                bus.bus_addr  = addr_q;
                state_d       = ST_SNOOP;
            end
            ST_SNOOP: begin
                bus.gnt = owner_q;
                if (snoop_tc) begin
                    if (|wb_m)              state_d = ST_WB;
                    else if (is_inv(cmd_q)) state_d = ST_DONE;
                    else                    state_d = ST_MEM;
                end
            end
            ST_WB: begin
                bus.gnt       = owner_q;
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wb_data_q;
                if (bus.mem_ack)
                    state_d = (cmd_q == CMD_WR_MISS) ? ST_MEM : ST_DONE;
            end
            ST_MEM: begin
                bus.gnt      = owner_q;
                bus.mem_addr = addr_q;
                if (cmd_q == CMD_WR_MISS) begin
                    bus.mem_wr    = 1'b1;
                    bus.mem_wdata = wdata_q;
                end else begin
                    bus.mem_rd = 1'b1;
                end
                if (bus.mem_ack) state_d = ST_DONE;
            end
            ST_DONE: begin
                bus.gnt        = owner_q;
                bus.done       = owner_q;
                bus.done_share = done_share_q;
                bus.done_data  = fill_q;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Transaction context: owner, request fields, snoop results, fill data, rr pointer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_q         <= '0;
            owner_idx_q  <= '0;
            owner_q      <= '0;
            cmd_q        <= CMD_RD_MISS;
            addr_q       <= '0;
            wdata_q      <= '0;
            wb_data_q    <= '0;
            fill_q       <= '0;
            snoop_cnt_q  <= '0;
            done_share_q <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|bus.req) begin
                        owner_q      <= win_oh;
                        owner_idx_q  <= win_idx;
                        cmd_q        <= win_cmd;
                        addr_q       <= win_addr;
                        wdata_q      <= win_wdata;
                        fill_q       <= '0;
                        done_share_q <= 1'b0;
                        snoop_cnt_q  <= CNT_W'(SNOOP_CYC);
                    end
                end
                ST_SNOOP: begin
                    if (!snoop_tc) begin
                        snoop_cnt_q <= snoop_cnt_q - CNT_W'(1);
                    end else begin
                        done_share_q <= |(share_m | wb_m);
                        wb_data_q    <= wb_sel;
                        if (multi_hot(MAX_PROC'(wb_m))) proto_err_q <= 1'b1;
                    end
                end
                ST_WB: begin
                    if (bus.mem_ack && cmd_q == CMD_RD_MISS) fill_q <= wb_data_q;
                end
                ST_MEM: begin
                    if (bus.mem_ack && cmd_q == CMD_RD_MISS) fill_q <= bus.mem_rdata;
                end
                ST_DONE: begin
                    rr_q <= (owner_idx_q == PTR_W'(N_PROC - 1)) ? '0
                                                                 : owner_idx_q + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
